// File: rtl/mmc_arb_pkg.sv
// Shared types and helpers for the mmc arbiter: FSM state encoding,
// default widths and circular index arithmetic.
package mmc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int LAT_W      = 16;

  // Index following idx in a ring of n entries.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mmc_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request bit at or after
// rr_ptr, searching circularly.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_req
);

  localparam int IW = $clog2(N);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    any_req   = |req;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mmc_arbiter.sv
// Round-robin sharing of one mmc component between N_REQ requesters,
// one outstanding call at a time, with call latency and watchdog reporting.
module mmc_arbiter
  import mmc_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic [N_REQ-1:0]          resp_valid,
  input  logic [N_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      mmc_start,
  input  logic                      mmc_busy,
  output logic [DATA_W-1:0]         mmc_a,
  output logic [DATA_W-1:0]         mmc_b,
  input  logic                      mmc_done,
  output logic                      mmc_stall,
  input  logic [DATA_W-1:0]         mmc_returndata,
  output logic [LAT_W-1:0]          last_latency,
  output logic                      err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [IDX_W-1:0]    grant_reg;
  logic [DATA_W-1:0]   a_reg, b_reg;
  logic [DATA_W-1:0]   resp_data_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [LAT_W-1:0]    last_lat_reg;
  logic [LAT_W-1:0]    lat_inc;
  logic                err_reg;

  logic [N_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                any_req;
  logic [N_REQ-1:0]    grant_onehot;
  logic [DATA_W-1:0]   a_sel, b_sel;
  logic                resp_hs;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
    end
  endgenerate

  assign a_sel   = req_a[int'(arb_idx)*DATA_W +: DATA_W];
  assign b_sel   = req_b[int'(arb_idx)*DATA_W +: DATA_W];
  assign lat_inc = (lat_cnt_reg == '1) ? lat_cnt_reg : lat_cnt_reg + 1'b1;
  // Only the granted requester's resp_ready bit completes the handshake.
  assign resp_hs = |(resp_ready & grant_onehot);

  assign mmc_a        = a_reg;
  assign mmc_b        = b_reg;
  assign resp_data    = resp_data_reg;
  assign last_latency = last_lat_reg;
  assign err_timeout  = err_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    resp_valid = '0;
    mmc_start  = 1'b0;
    mmc_stall  = 1'b1;
    case (state_reg)
      IDLE: begin
        // req_ready is combinational, so keep it low while reset is held.
        if (any_req && resetn) begin
          req_ready  = arb_grant;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mmc_start = 1'b1;
        if (!mmc_busy) state_next = WAIT;
      end
      WAIT: begin
        mmc_stall = 1'b0;
        if (mmc_done) state_next = RESP;
      end
      RESP: begin
        resp_valid = grant_onehot;
        if (resp_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      resp_data_reg <= '0;
      lat_cnt_reg   <= '0;
      last_lat_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg <= arb_idx;
            a_reg     <= a_sel;
            b_reg     <= b_sel;
          end
        end
        ISSUE: begin
          if (!mmc_busy) lat_cnt_reg <= '0;
        end
        WAIT: begin
          lat_cnt_reg <= lat_inc;
          if (mmc_done) begin
            resp_data_reg <= mmc_returndata;
            last_lat_reg  <= lat_inc;
          end
          // Watchdog only flags; the call is left running.
          if (32'(lat_cnt_reg) + 32'd1 >= 32'(TIMEOUT)) err_reg <= 1'b1;
        end
        RESP: begin
          if (resp_hs) rr_ptr_reg <= IDX_W'(next_idx(int'(grant_reg), N_REQ));
        end
        default: ;
      endcase
    end
  end

endmodule
